// File: rtl/pong_pkg.sv
// Shared types and heading helpers for the ball kinematics stage.
package pong_pkg;
  localparam int THETA_W = 6;
  localparam int TRIG_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_STEP, S_BOUNCE} state_e;

  // Vertical wall: mirror about the Y axis (pi - theta).
  function automatic logic [THETA_W-1:0] reflect_x(input logic [THETA_W-1:0] t);
    return THETA_W'(32) - t;
  endfunction

  // Horizontal wall: mirror about the X axis (-theta).
  function automatic logic [THETA_W-1:0] reflect_y(input logic [THETA_W-1:0] t);
    return THETA_W'(0) - t;
  endfunction
endpackage

// File: rtl/ball_motion_if.sv
// Control, status and sin/cos lookup signals of the ball kinematics stage.
interface ball_motion_if #(parameter int POS_W = 10);
  import pong_pkg::*;
  logic                      frame_i;
  logic                      launch_i;
  logic [THETA_W-1:0]        launch_theta_i;
  logic signed [TRIG_W-1:0]  sin_i;
  logic signed [TRIG_W-1:0]  cos_i;
  logic [THETA_W-1:0]        theta_o;
  logic [POS_W-1:0]          x_o;
  logic [POS_W-1:0]          y_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      hit_x_o;
  logic                      hit_y_o;

  modport master (output frame_i, launch_i, launch_theta_i, sin_i, cos_i,
                  input  theta_o, x_o, y_o, busy_o, done_o, hit_x_o, hit_y_o);
  modport slave  (input  frame_i, launch_i, launch_theta_i, sin_i, cos_i,
                  output theta_o, x_o, y_o, busy_o, done_o, hit_x_o, hit_y_o);
endinterface

// File: rtl/ball_axis.sv
// One-axis fixed-point position accumulator with wall clamp and out-of-range flag.
module ball_axis import pong_pkg::*; #(
  parameter int POS_W = 10,
  parameter int FRAC  = 7,
  parameter int MIN   = 0,
  parameter int MAX   = 639,
  parameter int START = 320
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     add_i,
  input  logic                     chk_i,
  input  logic signed [TRIG_W-1:0] delta_i,
  output logic [POS_W-1:0]         pos_o,
  output logic                     oor_o
);
  localparam int ACC_W = POS_W + FRAC + 1;
  localparam logic signed [ACC_W-1:0] START_ACC = ACC_W'(START) << FRAC;
  localparam logic signed [ACC_W-1:0] MIN_ACC   = ACC_W'(MIN) << FRAC;
  localparam logic signed [ACC_W-1:0] MAX_ACC   = ACC_W'(MAX) << FRAC;
  localparam logic signed [POS_W:0]   MIN_I     = (POS_W+1)'(MIN);
  localparam logic signed [POS_W:0]   MAX_I     = (POS_W+1)'(MAX);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [POS_W:0]   int_w;
  logic                    lo_w, hi_w;

  // Integer field keeps the spare sign bit so underflow reads as negative.
  assign int_w = acc_q[ACC_W-1:FRAC];
  assign lo_w  = int_w < MIN_I;
  assign hi_w  = int_w > MAX_I;
  assign oor_o = lo_w | hi_w;
  assign pos_o = acc_q[FRAC +: POS_W];

  always_comb begin
    acc_d = acc_q;
    if (load_i)     acc_d = START_ACC;
    else if (add_i) acc_d = acc_q + ACC_W'(delta_i);
    else if (chk_i) begin
      if (lo_w)      acc_d = MIN_ACC;
      else if (hi_w) acc_d = MAX_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= START_ACC;
    else        acc_q <= acc_d;
endmodule

// File: rtl/ball_motion.sv
// Ball kinematics: integrates lookup sin/cos into X/Y per frame and reflects heading on walls.
module ball_motion import pong_pkg::*; #(
  parameter int POS_W       = 10,
  parameter int FRAC        = 7,
  parameter int STEPS       = 2,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int X_START     = 320,
  parameter int Y_START     = 240,
  parameter int THETA_START = 5
) (
  input  logic         CLK,
  input  logic         RST_N,
  ball_motion_if.slave bus
);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [THETA_W-1:0] theta_q, theta_d;
  logic               done_q, done_d, hx_q, hx_d, hy_q, hy_d;
  logic               add_w, chk_w, oor_x, oor_y;

  assign add_w = (state_q == S_STEP)   && !bus.launch_i;
  assign chk_w = (state_q == S_BOUNCE) && !bus.launch_i;

  ball_axis #(.POS_W(POS_W), .FRAC(FRAC), .MIN(X_MIN), .MAX(X_MAX), .START(X_START)) u_x (
    .clk(CLK), .rst_n(RST_N), .load_i(bus.launch_i), .add_i(add_w), .chk_i(chk_w),
    .delta_i(bus.cos_i), .pos_o(bus.x_o), .oor_o(oor_x));

  ball_axis #(.POS_W(POS_W), .FRAC(FRAC), .MIN(Y_MIN), .MAX(Y_MAX), .START(Y_START)) u_y (
    .clk(CLK), .rst_n(RST_N), .load_i(bus.launch_i), .add_i(add_w), .chk_i(chk_w),
    .delta_i(bus.sin_i), .pos_o(bus.y_o), .oor_o(oor_y));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    theta_d = theta_q;
    done_d  = 1'b0;
    hx_d    = 1'b0;
    hy_d    = 1'b0;
    if (bus.launch_i) begin
      state_d = S_IDLE;
      theta_d = bus.launch_theta_i;
    end else begin
      unique case (state_q)
        S_IDLE:   if (bus.frame_i) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(STEPS - 1);
                  end
        S_SETTLE: state_d = S_STEP;
        S_STEP:   state_d = S_BOUNCE;
        S_BOUNCE: begin
          hx_d = oor_x;
          hy_d = oor_y;
          // Corner hit reverses the heading outright.
          if (oor_x && oor_y) theta_d = theta_q + THETA_W'(32);
          else if (oor_x)     theta_d = reflect_x(theta_q);
          else if (oor_y)     theta_d = reflect_y(theta_q);
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = cnt_q - 1'b1;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      theta_q <= THETA_W'(THETA_START);
      done_q  <= 1'b0;
      hx_q    <= 1'b0;
      hy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      theta_q <= theta_d;
      done_q  <= done_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
    end

  assign bus.theta_o = theta_q;
  assign bus.busy_o  = (state_q != S_IDLE);
  assign bus.done_o  = done_q;
  assign bus.hit_x_o = hx_q;
  assign bus.hit_y_o = hy_q;
endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
Ball kinematics stage that sits directly downstream of the sine/cosine lookup. It drives a 6-bit heading angle into the lookup. It consumes the returned 8-bit signed sin/cos values as per-step velocity and integrates them into fixed-point X/Y ball position once per frame tick. It reflects the heading on wall contact and reports bounce events to the game logic.

Parameters:
POS_W, 10, integer bits of each position coordinate
FRAC, 7, fractional bits of position accumulators (cos/sin of ±127 ≈ ±1 px/step)
STEPS, 2, integration steps per frame tick (≥1)
X_MIN, 0, leftmost legal integer X
X_MAX, 639, rightmost legal integer X
Y_MIN, 0, topmost legal integer Y
Y_MAX, 479, bottommost legal integer Y
X_START, 320, X after reset/launch
Y_START, 240, Y after reset/launch
THETA_START, 5, heading after reset

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
frame_i  input  1  one-cycle pulse: start one frame of motion
launch_i  input  1  one-cycle pulse: recentre ball, load launch_theta_i
launch_theta_i  input  6  heading loaded on launch
sin_i  input  8  two's-complement sin(theta_o) from lookup
cos_i  input  8  two's-complement cos(theta_o) from lookup
theta_o  output  6  current heading, 64 steps/revolution, to lookup
x_o  output  POS_W  integer part of X
y_o  output  POS_W  integer part of Y
busy_o  output  1  high while a frame is in progress
done_o  output  1  one-cycle pulse: frame complete
hit_x_o  output  1  one-cycle pulse: X wall bounce (left or right)
hit_y_o  output  1  one-cycle pulse: Y wall bounce (top or bottom)

Behaviour:
- Reset (async, RST_N low): x=X_START.0 and y=Y_START.0 (fraction 0), theta_o=THETA_START, state IDLE, busy_o/done_o/hit_x_o/hit_y_o=0.
- Accumulators are POS_W+FRAC+1 bits (extra sign bit for under/overflow detection). Outputs are the integer field only.
- FSM: IDLE → SETTLE → STEP → BOUNCE → (SETTLE if steps remain, else IDLE).
- IDLE: frame_i → SETTLE, step counter=STEPS-1, busy_o=1.
- SETTLE: one cycle. theta_o is held stable so that a registered lookup variant is also valid.
- STEP: x += sext(cos_i), y += sext(sin_i). The increment is added at the LSB of the fractional field.
- BOUNCE, X axis: int(x) > X_MAX → x=X_MAX.0, theta=(32-theta) mod 64, hit_x_o pulse. Negative x or int(x) < X_MIN → x=X_MIN.0, same reflection, same pulse.
- BOUNCE, Y axis: out of range → clamp to Y_MAX.0 or Y_MIN.0, theta=(64-theta) mod 64, hit_y_o pulse.
- BOUNCE, both axes out of range in the same step: clamp both, theta=(theta+32) mod 64, both pulses asserted in the same cycle.
- After the final BOUNCE: state IDLE, busy_o=0, done_o high for exactly one cycle.
- Latency: done_o is high in the cycle following the 3·STEPS-th edge after the edge that samples frame_i.
- Hit pulses are registered outputs of BOUNCE; they are high during the cycle following the BOUNCE edge.
- frame_i while busy: ignored, no queueing.
- launch_i in any state: x=X_START.0, y=Y_START.0, theta=launch_theta_i, state IDLE, busy_o=0. No done_o or hit pulses are generated.
- launch_i and frame_i in the same cycle: launch wins, frame is dropped.
- Heading arithmetic is 6-bit modular and wraps naturally (e.g. 32-40 → 56).

Decomposition:
- Shared package pong_pkg: THETA_W=6, TRIG_W=8, FSM state enum, and functions reflect_x(theta), reflect_y(theta).
- Sub-module ball_axis: one-axis accumulator with add, range check, clamp and hit flag, parameterised by MIN/MAX/START. It is instantiated twice (X with cos, Y with sin). ball_motion holds the FSM, step counter and heading.

Test Plan:
1. Reset, then release → x_o=320, y_o=240, theta_o=5, busy_o=0. All pulses stay 0 through 10 idle cycles.
2. launch theta=0, drive cos_i=127, sin_i=0, pulse frame_i → busy_o high for 6 cycles, done_o pulse, x_o=321, y_o=240 (accum 320·128+254), no hits.
3. Instance X_MAX=320, launch theta=0, cos_i=127, frame → step 2 overflows → x_o=320, theta_o=32, single hit_x_o pulse, hit_y_o=0.
4. Instance Y_MIN=239, launch theta=48, sin_i=-128, cos_i=0 → step 1 y=239.0 no hit; step 2 y<239 → y_o=239, theta_o=16, one hit_y_o pulse.
5. Instance X_MAX=320, Y_MAX=240, launch theta=8, cos_i=sin_i=127 → step 2 both out → x_o=320, y_o=240, theta_o=40, hit_x_o and hit_y_o in the same cycle.
6. frame_i, then launch_i (theta=3) in the 2nd busy cycle, plus a frame_i during busy → immediate IDLE, x_o=320, y_o=240, theta_o=3, no done_o. Next frame_i runs normally.
